// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and flow controller for the iCache read port.
//
// Drives a word index into a synchronous-read iCache (one cycle of latency,
// no enable). The read issued in one cycle returns in the next. A one-entry
// skid slot holds that returned word when decode stalls. The module offers
// {pc, inst} to decode and applies branch redirects.
//
// Ports
//   clk              clock; all state updates on the rising edge
//   reset            synchronous, active-high
//   icache_addr      word index = fetch_pc[ADDR_WIDTH+1:2]
//   icache_rdata     mem[icache_addr of the previous cycle]
//   redirect_valid_i flush all pending work and restart at redirect_pc_i
//   redirect_pc_i    redirect target; bits [1:0] are ignored
//   valid_o          {pc_o, inst_o} is offered to decode
//   ready_i          decode accepts the offer this cycle
//   pc_o / inst_o    offered PC and instruction; both are 0 when !valid_o
//   fire_count_o     count of valid_o && ready_i handshakes; wraps at 2**32
//   slot_state       current slot FSM state (EMPTY=0, STREAM=1, HOLD=2)
//
// Handshake: a transfer happens in any cycle where valid_o && ready_i are both
// high at the rising edge. The offer is taken in that cycle, and the next
// offer (if any) appears in the following cycle. valid_o does not depend on
// ready_i. A redirect or reset in the same cycle forces valid_o low, so no
// transfer happens in that cycle.
module fetch_ctrl #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic [DATA_WIDTH-1:0] icache_rdata,
  input  logic                  redirect_valid_i,
  input  logic [31:0]           redirect_pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           pc_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [31:0]           fire_count_o,
  output logic [1:0]            slot_state
);

  // STREAM: a read was issued last cycle, and its data is on icache_rdata now.
  // HOLD:   a returned word is parked in the skid slot.
  // The two are mutually exclusive by construction.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } slot_e;

  slot_e                 slot_q, slot_d;
  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [31:0]           infl_pc_q;
  logic [31:0]           skid_pc_q;
  logic [DATA_WIDTH-1:0] skid_inst_q;
  logic [31:0]           fire_count_q;

  logic issue;
  logic capture_skid;
  logic fire;
  logic [1:0] unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc_i[1:0];

  assign icache_addr  = fetch_pc_q[ADDR_WIDTH+1:2];
  assign fire_count_o = fire_count_q;
  assign slot_state   = slot_q;

  // Output mux. Gating with reset keeps a mid-stream reset from offering
  // (and counting) a stale instruction.
  always_comb begin
    valid_o = 1'b0;
    pc_o    = 32'd0;
    inst_o  = '0;
    if (!reset && !redirect_valid_i) begin
      if (slot_q == HOLD) begin
        valid_o = 1'b1;
        pc_o    = skid_pc_q;
        inst_o  = skid_inst_q;
      end else if (slot_q == STREAM) begin
        valid_o = 1'b1;
        pc_o    = infl_pc_q;
        inst_o  = icache_rdata;
      end
    end
  end

  assign fire = valid_o && ready_i;

  // Next-state logic. A new read is issued whenever the current offer is
  // consumed (ready_i), or when there is nothing in flight at all.
  // Issuing always leads to STREAM. This gives the zero-bubble restart
  // out of HOLD.
  always_comb begin
    slot_d       = slot_q;
    fetch_pc_d   = fetch_pc_q;
    capture_skid = 1'b0;
    issue        = !redirect_valid_i && (ready_i || (slot_q == EMPTY));
    if (redirect_valid_i) begin
      slot_d     = EMPTY;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (issue) begin
      slot_d     = STREAM;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else if (slot_q == STREAM) begin
      // Decode stalled while read data is arriving. Park the data now,
      // because icache_rdata changes next cycle.
      slot_d       = HOLD;
      capture_skid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= EMPTY;
      fetch_pc_q   <= RESET_PC;
      infl_pc_q    <= 32'd0;
      skid_pc_q    <= 32'd0;
      skid_inst_q  <= '0;
      fire_count_q <= 32'd0;
    end else begin
      slot_q     <= slot_d;
      fetch_pc_q <= fetch_pc_d;
      if (issue) begin
        infl_pc_q <= fetch_pc_q;
      end
      if (capture_skid) begin
        skid_pc_q   <= infl_pc_q;
        skid_inst_q <= icache_rdata;
      end
      if (fire) begin
        fire_count_q <= fire_count_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with an iCache model preloaded as mem[i] = 32'h1000_0000 + i.
// The driver pushes one expected record per driven cycle. The monitor pops and
// compares that record on the falling edge of the same cycle.
module tb_fetch_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  // Record layout: {check_count, valid, pc, inst, fire_count}
  localparam int W  = 1 + 1 + 32 + DW + 32;

  logic          clk;
  logic          reset;
  logic [AW-1:0] icache_addr;
  logic [DW-1:0] icache_rdata;
  logic          redirect_valid_i;
  logic [31:0]   redirect_pc_i;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   pc_o;
  logic [DW-1:0] inst_o;
  logic [31:0]   fire_count_o;
  logic [1:0]    slot_state;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] mem[2**AW];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [31:0]   exp_cnt = 32'd0;

  fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .icache_addr      (icache_addr),
    .icache_rdata     (icache_rdata),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .fire_count_o     (fire_count_o),
    .slot_state       (slot_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'h1000_0000 + i;
  end

  // Synchronous-read iCache: the data appears one cycle after the address.
  always @(posedge clk) icache_rdata <= mem[icache_addr];

  // Driver: applies one cycle of inputs and pushes the expected outputs for it.
  task automatic step(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc,
                      input bit ev, input logic [31:0] epc, input logic [DW-1:0] einst,
                      input bit cc);
    @(posedge clk);
    #1;
    reset            = rst;
    ready_i          = rdy;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    exp_q.push_back({cc, ev, epc, einst, exp_cnt});
    if (rst) exp_cnt = 32'd0;
    else if (ev && rdy) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Cycles with nothing offered.
  task automatic idle(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
    step(rst, rdy, rv, rpc, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  // Offer expected at pc, with ready_i = rdy.
  task automatic offer(input bit rdy, input logic [31:0] pc, input logic [DW-1:0] inst);
    step(1'b0, rdy, 1'b0, 32'd0, 1'b1, pc, inst, 1'b1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      n_cmp++;
      if (valid_o !== e[W-2]) begin
        n_err++;
        $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid_o, e[W-2]);
      end
      n_cmp++;
      if (pc_o !== e[W-3 -: 32]) begin
        n_err++;
        $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, pc_o, e[W-3 -: 32]);
      end
      n_cmp++;
      if (inst_o !== e[DW+31 -: DW]) begin
        n_err++;
        $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst_o, e[DW+31 -: DW]);
      end
      if (e[W-1]) begin
        n_cmp++;
        if (fire_count_o !== e[31:0]) begin
          n_err++;
          $display("FAIL fire_count cyc=%0d got=%0d exp=%0d", cyc, fire_count_o, e[31:0]);
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    ready_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'd0;

    // 1: reset for 3 cycles. The count is unknown until the first reset edge.
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(1'b1, 1'b0, 1'b0, 32'd0);
    idle(1'b1, 1'b0, 1'b0, 32'd0);
    idle(1'b0, 1'b1, 1'b0, 32'd0);                 // issue PC 0, nothing offered yet
    offer(1'b1, 32'h00, 32'h1000_0000);
    offer(1'b1, 32'h04, 32'h1000_0001);
    offer(1'b1, 32'h08, 32'h1000_0002);
    offer(1'b1, 32'h0C, 32'h1000_0003);
    offer(1'b1, 32'h10, 32'h1000_0004);

    // 2: stall for 3 cycles on PC 0x14, then release with no bubble.
    offer(1'b0, 32'h14, 32'h1000_0005);
    offer(1'b0, 32'h14, 32'h1000_0005);
    offer(1'b0, 32'h14, 32'h1000_0005);
    offer(1'b1, 32'h14, 32'h1000_0005);
    offer(1'b1, 32'h18, 32'h1000_0006);

    // 3: redirect to 0x20 while streaming.
    idle(1'b0, 1'b1, 1'b1, 32'h20);
    idle(1'b0, 1'b1, 1'b0, 32'd0);
    offer(1'b1, 32'h20, 32'h1000_0008);
    offer(1'b1, 32'h24, 32'h1000_0009);
    offer(1'b1, 32'h28, 32'h1000_000A);
    offer(1'b1, 32'h2C, 32'h1000_000B);
    offer(1'b1, 32'h30, 32'h1000_000C);
    offer(1'b1, 32'h34, 32'h1000_000D);
    offer(1'b1, 32'h38, 32'h1000_000E);
    offer(1'b1, 32'h3C, 32'h1000_000F);

    // 4: the word index wraps past PC 0x3C.
    offer(1'b1, 32'h40, 32'h1000_0000);
    offer(1'b1, 32'h44, 32'h1000_0001);

    // 5: redirect while in HOLD, with an unaligned target.
    offer(1'b0, 32'h48, 32'h1000_0002);
    offer(1'b0, 32'h48, 32'h1000_0002);
    idle(1'b0, 1'b1, 1'b1, 32'h13);
    idle(1'b0, 1'b1, 1'b0, 32'd0);
    offer(1'b1, 32'h10, 32'h1000_0004);
    offer(1'b1, 32'h14, 32'h1000_0005);

    // 6: a one-cycle reset mid-stream.
    idle(1'b1, 1'b1, 1'b0, 32'd0);
    idle(1'b0, 1'b1, 1'b0, 32'd0);
    offer(1'b1, 32'h00, 32'h1000_0000);
    offer(1'b1, 32'h04, 32'h1000_0001);
    offer(1'b0, 32'h08, 32'h1000_0002);

    // Drain the scoreboard, with a cycle budget.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
